// File: rtl/pwm_decoder.sv
// PWM receive decoder: measures high-time and period of a synchronised PWM stream
// and publishes high_cnt - OFFSET as a signed sample, with period-error and stuck-line flags.
module pwm_decoder #(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int OFFSET        = 512
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  PWMIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  PeriodErr,
  output logic                  Stuck
);
  localparam int CW = COUNTER_WIDTH + 2;
  localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_NOM     = CNT_ONE << COUNTER_WIDTH;
  localparam logic [CW-1:0] CNT_TIMEOUT = CNT_ONE << (COUNTER_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [DATA_WIDTH-1:0] OFFSET_W = DATA_WIDTH'(OFFSET);
  localparam logic [DATA_WIDTH-1:0] NOM_W    = DATA_WIDTH'(CNT_NOM);

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    s1_q, s2_q, s3_q;
  logic [CW-1:0]           per_cnt_q, per_cnt_d;
  logic [CW-1:0]           high_cnt_q, high_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    perr_q, perr_d;
  logic                    stuck_q, stuck_d;
  logic                    rise_s, fall_s, timeout_s;

  assign rise_s    = s2_q & ~s3_q;
  assign fall_s    = ~s2_q & s3_q;
  assign timeout_s = (per_cnt_q == CNT_TIMEOUT) & ~rise_s;

  // Next-state: rise has priority over timeout; publish uses pre-update counters.
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q + CNT_ONE;
    high_cnt_d = high_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    stuck_d    = stuck_q;
    if (s2_q && (high_cnt_q != CNT_MAX)) begin
      high_cnt_d = high_cnt_q + CNT_ONE;
    end else begin
      high_cnt_d = high_cnt_q;
    end
    if (rise_s) begin
      per_cnt_d  = CNT_ONE;
      high_cnt_d = CNT_ONE;
      state_d    = ST_HIGH;
      if (state_q == ST_LOW) begin
        data_d  = DATA_WIDTH'(high_cnt_q) - OFFSET_W;
        perr_d  = (per_cnt_q != CNT_NOM);
        stuck_d = 1'b0;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (timeout_s) begin
      data_d     = (s2_q ? NOM_W : {DATA_WIDTH{1'b0}}) - OFFSET_W;
      stuck_d    = 1'b1;
      perr_d     = 1'b1;
      valid_d    = 1'b1;
      per_cnt_d  = CNT_ONE;
      high_cnt_d = {CW{1'b0}};
      state_d    = s2_q ? ST_HIGH : ST_LOW;
    end else begin
      case (state_q)
        ST_SEEK: state_d = ST_SEEK;
        ST_HIGH: begin
          if (fall_s) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_HIGH;
          end
        end
        ST_LOW:  state_d = ST_LOW;
        default: state_d = ST_SEEK;
      endcase
    end
  end

  // State, synchroniser and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_SEEK;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      per_cnt_q  <= {CW{1'b0}};
      high_cnt_q <= {CW{1'b0}};
      data_q     <= {DATA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= PWMIn;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      stuck_q    <= stuck_d;
    end
  end

  assign DataOut   = data_q;
  assign DataValid = valid_q;
  assign PeriodErr = perr_q;
  assign Stuck     = stuck_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: history-based reference model over the driven
// PWM samples, scoreboard of expected publishes, per-cycle output checks.
module tb_pwm_decoder;
  localparam int NOM  = 1024;
  localparam int TO   = 2048;
  localparam int OFF  = 512;
  localparam int MAXC = 100000;

  typedef struct {
    int unsigned e;
    logic [11:0] d;
    logic        p;
    logic        s;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        PWMIn;
  logic [11:0] DataOut;
  logic        DataValid;
  logic        PeriodErr;
  logic        Stuck;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  bit          hist [MAXC];
  int          c = 0;
  bit          c_rise = 1'b0;
  bit          synced = 1'b0;
  logic        prev = 1'b0;
  exp_t        sb_q[$];
  logic [11:0] last_d = 12'h000;
  logic        last_p = 1'b0;
  logic        last_s = 1'b0;

  pwm_decoder #(.DATA_WIDTH(12), .COUNTER_WIDTH(10), .OFFSET(512)) dut (
    .clk(clk),
    .rstn(rstn),
    .PWMIn(PWMIn),
    .DataOut(DataOut),
    .DataValid(DataValid),
    .PeriodErr(PeriodErr),
    .Stuck(Stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference model in the input-sample domain; every effect lands two edges later.
  task automatic model_step(input int n, input logic v, input logic r);
    logic vv;
    int   h;
    exp_t x;
    vv = r ? v : 1'b0;
    if (n < MAXC) hist[n] = vv;
    if (!r) begin
      synced = 1'b0;
      c      = n - 1;
      c_rise = 1'b0;
      prev   = 1'b0;
      sb_q.delete();
      last_d = 12'h000;
      last_p = 1'b0;
      last_s = 1'b0;
    end else begin
      if (vv && !prev) begin
        if (synced) begin
          h = 0;
          for (int i = (c_rise ? c : c + 1); i < n; i++) h += int'(hist[i]);
          x.e = n + 2;
          x.d = 12'(h - OFF);
          x.p = ((n - c) != NOM);
          x.s = 1'b0;
          sb_q.push_back(x);
        end
        c      = n;
        c_rise = 1'b1;
        synced = 1'b1;
      end else if ((n - c) == TO) begin
        x.e = n + 2;
        x.d = vv ? 12'(NOM - OFF) : 12'(0 - OFF);
        x.p = 1'b1;
        x.s = 1'b1;
        sb_q.push_back(x);
        c      = n;
        c_rise = 1'b0;
        synced = 1'b1;
      end
      prev = vv;
    end
  endtask

  task automatic tick_r(input logic v, input logic r);
    PWMIn = v;
    rstn  = r;
    @(posedge clk);
    #1;
    model_step(int'(cyc), v, r);
  endtask

  task automatic tick(input logic v);
    tick_r(v, 1'b1);
  endtask

  task automatic send_period(input int p, input int h);
    for (int i = 0; i < h; i++) tick(1'b1);
    for (int i = 0; i < p - h; i++) tick(1'b0);
  endtask

  // Per-cycle monitor: DataValid exactly when scheduled, outputs hold otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_v;
      exp_t ev;
      exp_v = (sb_q.size() > 0) && (sb_q[0].e == cyc);
      if (exp_v) begin
        ev = sb_q.pop_front();
        last_d = ev.d;
        last_p = ev.p;
        last_s = ev.s;
      end
      check_eq("valid", 32'(DataValid), 32'(exp_v));
      check_eq("data", 32'(DataOut), 32'(last_d));
      check_eq("perr", 32'(PeriodErr), 32'(last_p));
      check_eq("stuck", 32'(Stuck), 32'(last_s));
    end
  end

  initial begin
    int p;
    int h;
    rstn  = 1'b0;
    PWMIn = 1'b0;
    repeat (3) tick_r(1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (10) tick(1'b0);

    repeat (3) send_period(1024, 512);
    send_period(1024, 100);
    send_period(1024, 1023);
    send_period(1024, 100);
    send_period(1000, 600);
    send_period(1024, 512);
    send_period(1024, 512);

    repeat (16) begin
      p = int'($urandom_range(1200, 3));
      h = int'($urandom_range(p - 1, 1));
      send_period(p, h);
    end

    for (int d = -512; d < 512; d += 61) send_period(1024, d + 512);
    send_period(1024, 512);
    send_period(1024, 1023);

    // Reset in the middle of a high phase; the line stays high through it.
    repeat (300) tick(1'b1);
    repeat (3) tick_r(1'b1, 1'b0);
    repeat (397) tick(1'b1);
    repeat (324) tick(1'b0);
    repeat (2) send_period(1024, 512);

    repeat (5000) tick(1'b0);
    repeat (2) send_period(1024, 512);

    repeat (5000) tick(1'b1);
    repeat (300) tick(1'b0);
    repeat (3) send_period(1024, 512);
    repeat (8) tick(1'b0);

    check_eq("drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Recovers the data word from a PWM waveform by measuring high-time per period and removing the offset. It is the receive-side counterpart of the PWM generator, decoding the 1-bit PWM stream back to a signed sample. It is used for loopback checks and for reading externally generated PWM. Output format is chosen so that a generator driven with DataIn yields DataOut == DataIn.

## Interface
- DATA_WIDTH, 12, output word width; must be >= COUNTER_WIDTH+2
- COUNTER_WIDTH, 10, nominal period is 2^COUNTER_WIDTH clk cycles
- OFFSET, 512, subtracted from measured high count
- clk  input  1  clock; all logic on rising edge
- rstn  input  1  reset, synchronous, active-low
- PWMIn  input  1  PWM stream, asynchronous to clk
- DataOut  output  DATA_WIDTH  decoded sample, two's complement, registered
- DataValid  output  1  one-cycle pulse when DataOut updates
- PeriodErr  output  1  last measured period != 2^COUNTER_WIDTH
- Stuck  output  1  no rising edge within timeout

## Operation
- Input sync: 3-flop chain s1→s2→s3; rise = s2 & ~s3, fall = ~s2 & s3.
- Counters per_cnt, high_cnt are COUNTER_WIDTH+2 bits wide.
- On rise: per_cnt <= 1, high_cnt <= 1. Every other cycle: per_cnt++; high_cnt++ iff s2==1.
- FSM states:
  - SEEK (reset state): waits for the first rise, then → HIGH. No publish; the first partial period is discarded.
  - HIGH: fall → LOW.
  - LOW: rise → publish, → HIGH.
- Publish (on rise in LOW):
  - DataOut <= high_cnt − OFFSET, computed modulo 2^DATA_WIDTH, using the pre-update counter values.
  - PeriodErr <= (per_cnt != 2^COUNTER_WIDTH).
  - Stuck <= 0; DataValid <= 1.
- Timeout, checked in any state, when per_cnt == 2^(COUNTER_WIDTH+1) and there is no rise that cycle:
  - DataOut <= (s2 ? 2^COUNTER_WIDTH : 0) − OFFSET.
  - Stuck <= 1, PeriodErr <= 1, DataValid <= 1.
  - per_cnt <= 1, high_cnt <= 0.
  - State → LOW if s2==0, else HIGH.
  - Timeout repeats every 2^(COUNTER_WIDTH+1) cycles while the line stays static.
- Simultaneous rise and timeout: rise wins (normal publish).
- high_cnt saturates at the all-ones value; it never wraps.
- DataOut, PeriodErr and Stuck hold between publishes.

## Timing
- Reset: DataOut=0, DataValid=0, PeriodErr=0, Stuck=0, state SEEK, sync flops and counters 0.
- Reset asserted mid-period: all of the above at the next clk edge. After release, the first rise is discarded.
- Latency: a PWMIn rising edge sampled into s1 at edge k gives DataOut/DataValid registered at edge k+2, so DataValid is high for exactly the cycle after edge k+2.
- High-time measured = number of cycles s2 was 1 within the period, exact to ±0 cycles for a clean synchronous input.
- DataValid is never asserted on two consecutive cycles. Minimum spacing equals the input period, which must be ≥ 3 cycles to resolve the high and low phases.

## Test plan
- Period 1024, high 512, continuous → after the discarded first period, DataValid once per 1024 cycles, DataOut=12'h000, PeriodErr=0, Stuck=0.
- Period 1024, high 100 → DataOut=12'hE64 (−412); then change to high 1023 → next publish 12'h1FF.
- PWMIn held low 5000 cycles → DataValid at per_cnt=2048 and every 2048 cycles thereafter, DataOut=12'hE00, Stuck=1, PeriodErr=1. A later normal period clears Stuck.
- PWMIn held high → DataOut=12'h200, Stuck=1.
- Period 1000, high 600 → DataOut=12'h058, PeriodErr=1. Return to period 1024 → PeriodErr=0 on the next publish.
- Loopback from the PWM generator (same parameters), DataIn sweeping −512..511:
  - DataOut equals each DataIn, with PeriodErr=0.
  - Assert rstn low for 3 cycles mid-HIGH → all outputs 0 on the next edge, and no DataValid until the second rise after release.
